// File: rtl/alu_seq.sv
// alu_seq: multi-cycle execute unit with valid/ready request and response channels.
// Define ALU_SEQ_BARREL_SHIFT_EN to get single-step shifts; otherwise shifts move one bit per cycle.

package alu_seq_pkg;
    localparam int kALU_OP_SEL_WIDTH     = 4;
    localparam int kALU_BRANCH_SEL_WIDTH = 3;

    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_ILLEGAL = 4'd0;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_ADD     = 4'd1;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SUB     = 4'd2;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_AND     = 4'd3;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_OR      = 4'd4;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_XOR     = 4'd5;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SLT     = 4'd6;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SLL     = 4'd7;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SRL     = 4'd8;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_SRA     = 4'd9;

    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_BRANCH_NONE = 3'd0;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_BRANCH_BEQ  = 3'd1;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_BRANCH_BNE  = 3'd2;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_BRANCH_BLT  = 3'd3;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_BRANCH_BGE  = 3'd4;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_BRANCH_BLTU = 3'd5;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_BRANCH_BGEU = 3'd6;
endpackage

module alu_seq
    import alu_seq_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             req_valid_i,
    output logic                             req_ready_o,
    input  logic [kALU_OP_SEL_WIDTH-1:0]     op_sel_i,
    input  logic [kALU_BRANCH_SEL_WIDTH-1:0] branch_sel_i,
    input  logic                             cmp_unsigned_i,
    input  logic [31:0]                      a_i,
    input  logic [31:0]                      b_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [31:0]                      result_o,
    output logic                             branch_taken_o,
    output logic                             illegal_o
);

`ifdef ALU_SEQ_BARREL_SHIFT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;
`endif

    state_t      state_q;
    logic [31:0] result_q;
    logic        taken_q;
    logic        illegal_q;

    logic [4:0]  shamt;
    logic        eq;
    logic        lt_s;
    logic        lt_u;
    logic [31:0] op_res;
    logic        op_ill;
    logic        br_taken;
    logic        br_ill;
    logic        is_branch;

    assign shamt     = b_i[4:0];
    assign eq        = (a_i == b_i);
    assign lt_s      = ($signed(a_i) < $signed(b_i));
    assign lt_u      = (a_i < b_i);
    assign is_branch = (branch_sel_i != kSAIL_BRANCH_NONE);

    always_comb begin
        op_res = 32'd0;
        op_ill = 1'b0;
        case (op_sel_i)
            kSAIL_ALUCTL_ADD: op_res = a_i + b_i;
            kSAIL_ALUCTL_SUB: op_res = a_i - b_i;
            kSAIL_ALUCTL_AND: op_res = a_i & b_i;
            kSAIL_ALUCTL_OR:  op_res = a_i | b_i;
            kSAIL_ALUCTL_XOR: op_res = a_i ^ b_i;
            kSAIL_ALUCTL_SLT: op_res = {31'd0, (cmp_unsigned_i ? lt_u : lt_s)};
`ifdef ALU_SEQ_BARREL_SHIFT_EN
            kSAIL_ALUCTL_SLL: op_res = a_i << shamt;
            kSAIL_ALUCTL_SRL: op_res = a_i >> shamt;
            kSAIL_ALUCTL_SRA: op_res = $unsigned($signed(a_i) >>> shamt);
`else
            // Nonzero amounts go to the iterative path; only shift-by-0 lands here.
            kSAIL_ALUCTL_SLL,
            kSAIL_ALUCTL_SRL,
            kSAIL_ALUCTL_SRA: op_res = a_i;
`endif
            default:          op_ill = 1'b1;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        br_ill   = 1'b0;
        case (branch_sel_i)
            kSAIL_BRANCH_BEQ:  br_taken = eq;
            kSAIL_BRANCH_BNE:  br_taken = ~eq;
            kSAIL_BRANCH_BLT:  br_taken = lt_s;
            kSAIL_BRANCH_BGE:  br_taken = ~lt_s;
            kSAIL_BRANCH_BLTU: br_taken = lt_u;
            kSAIL_BRANCH_BGEU: br_taken = ~lt_u;
            default:           br_ill   = 1'b1;
        endcase
    end

`ifndef ALU_SEQ_BARREL_SHIFT_EN
    logic [31:0]                  work_q;
    logic [4:0]                   count_q;
    logic [kALU_OP_SEL_WIDTH-1:0] shift_op_q;
    logic [31:0]                  work_nxt;
    logic                         start_shift;

    assign start_shift = (shamt != 5'd0) &&
                         ((op_sel_i == kSAIL_ALUCTL_SLL) ||
                          (op_sel_i == kSAIL_ALUCTL_SRL) ||
                          (op_sel_i == kSAIL_ALUCTL_SRA));

    always_comb begin
        case (shift_op_q)
            kSAIL_ALUCTL_SLL: work_nxt = {work_q[30:0], 1'b0};
            kSAIL_ALUCTL_SRL: work_nxt = {1'b0, work_q[31:1]};
            default:          work_nxt = {work_q[31], work_q[31:1]};
        endcase
    end
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            result_q   <= 32'd0;
            taken_q    <= 1'b0;
            illegal_q  <= 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
            work_q     <= 32'd0;
            count_q    <= 5'd0;
            shift_op_q <= kSAIL_ALUCTL_ILLEGAL;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        if (is_branch) begin
                            result_q  <= 32'd0;
                            taken_q   <= br_taken;
                            illegal_q <= br_ill;
                            state_q   <= ST_DONE;
                        end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
                        else if (start_shift) begin
                            work_q     <= a_i;
                            count_q    <= shamt;
                            shift_op_q <= op_sel_i;
                            result_q   <= 32'd0;
                            taken_q    <= 1'b0;
                            illegal_q  <= 1'b0;
                            state_q    <= ST_SHIFT;
                        end
`endif
                        else begin
                            result_q  <= op_res;
                            taken_q   <= 1'b0;
                            illegal_q <= op_ill;
                            state_q   <= ST_DONE;
                        end
                    end
                end
`ifndef ALU_SEQ_BARREL_SHIFT_EN
                ST_SHIFT: begin
                    work_q  <= work_nxt;
                    count_q <= count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        result_q <= work_nxt;
                        state_q  <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (rsp_ready_i) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Ready is masked by reset so it reads 0 for the whole time reset is held.
    assign req_ready_o    = (state_q == ST_IDLE) && !reset_i;
    assign rsp_valid_o    = (state_q == ST_DONE);
    assign result_o       = result_q;
    assign branch_taken_o = taken_q;
    assign illegal_o      = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors; expectations are queued at accept and checked by a response monitor.

module tb_alu_seq;
    import alu_seq_pkg::*;

    logic                             clk;
    logic                             reset_i;
    logic                             req_valid_i;
    logic                             req_ready_o;
    logic [kALU_OP_SEL_WIDTH-1:0]     op_sel_i;
    logic [kALU_BRANCH_SEL_WIDTH-1:0] branch_sel_i;
    logic                             cmp_unsigned_i;
    logic [31:0]                      a_i;
    logic [31:0]                      b_i;
    logic                             rsp_valid_o;
    logic                             rsp_ready_i;
    logic [31:0]                      result_o;
    logic                             branch_taken_o;
    logic                             illegal_o;

    alu_seq dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .op_sel_i       (op_sel_i),
        .branch_sel_i   (branch_sel_i),
        .cmp_unsigned_i (cmp_unsigned_i),
        .a_i            (a_i),
        .b_i            (b_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .result_o       (result_o),
        .branch_taken_o (branch_taken_o),
        .illegal_o      (illegal_o)
    );

    typedef struct {
        logic [31:0] result;
        logic        taken;
        logic        illegal;
        int          cyc;
    } exp_t;

    exp_t  sb_q[$];
    int    checks = 0;
    int    fails  = 0;
    int    cyc    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

`ifdef ALU_SEQ_BARREL_SHIFT_EN
    function automatic int shift_lat(input int k);
        return 0;
    endfunction
`else
    function automatic int shift_lat(input int k);
        return k;
    endfunction
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: checks on the first valid cycle, then stability while held.
    logic        in_rsp = 1'b0;
    exp_t        cur;
    always @(negedge clk) begin
        if (reset_i) begin
            in_rsp = 1'b0;
        end else if (rsp_valid_o) begin
            if (!in_rsp) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_rsp: response with no pending request (cycle %0d)", cyc);
                    cur.result = result_o; cur.taken = branch_taken_o;
                    cur.illegal = illegal_o; cur.cyc = cyc;
                end else begin
                    cur = sb_q.pop_front();
                    check("rsp_result",  result_o, cur.result);
                    check("rsp_taken",   {31'd0, branch_taken_o}, {31'd0, cur.taken});
                    check("rsp_illegal", {31'd0, illegal_o}, {31'd0, cur.illegal});
                    check("rsp_latency", cyc, cur.cyc);
                end
                in_rsp = 1'b1;
            end else begin
                check("hold_result", result_o, cur.result);
                check("hold_flags", {30'd0, branch_taken_o, illegal_o}, {30'd0, cur.taken, cur.illegal});
            end
            check("ready_in_done", {31'd0, req_ready_o}, 32'd0);
            if (rsp_ready_i) in_rsp = 1'b0;
        end
    end

    task automatic issue(input logic [kALU_OP_SEL_WIDTH-1:0] op,
                         input logic [kALU_BRANCH_SEL_WIDTH-1:0] br,
                         input logic uns, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e_res, input logic e_tk, input logic e_ill,
                         input int lat);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL issue_timeout: req_ready_o stuck at 0 expected 1");
            return;
        end
        op_sel_i = op; branch_sel_i = br; cmp_unsigned_i = uns; a_i = a; b_i = b;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        e.result = e_res; e.taken = e_tk; e.illegal = e_ill; e.cyc = cyc + lat;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || rsp_valid_o) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding expected 0", sb_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_i = 1'b1; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        op_sel_i = kSAIL_ALUCTL_ADD; branch_sel_i = kSAIL_BRANCH_NONE;
        cmp_unsigned_i = 1'b0; a_i = 32'd0; b_i = 32'd0;
        #3;
        check("reset_ready", {31'd0, req_ready_o}, 32'd0);
        check("reset_outs", {result_o[31:3], rsp_valid_o, branch_taken_o, illegal_o}, 32'd0);
        repeat (2) @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("ready_after_release", {31'd0, req_ready_o}, 32'd1);

        // Reset during an iterative SLL by 20: no response may ever appear.
        @(negedge clk);
        op_sel_i = kSAIL_ALUCTL_SLL; branch_sel_i = kSAIL_BRANCH_NONE;
        a_i = 32'd1; b_i = 32'd20; req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
`ifndef ALU_SEQ_BARREL_SHIFT_EN
        repeat (3) @(posedge clk);
        #1;
        check("ready_in_shift", {31'd0, req_ready_o}, 32'd0);
        check("valid_in_shift", {31'd0, rsp_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        #1;
        check("midshift_reset_outs", {result_o[31:3], rsp_valid_o, branch_taken_o, illegal_o}, 32'd0);
        check("midshift_reset_result", result_o, 32'd0);
        check("midshift_reset_ready", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("midshift_ready_release", {31'd0, req_ready_o}, 32'd1);
        repeat (30) @(posedge clk);
`else
        // With the barrel shifter the op completes at once; consume it normally.
        sb_q.push_back('{result: 32'h0010_0000, taken: 1'b0, illegal: 1'b0, cyc: cyc});
        drain();
`endif

        issue(kSAIL_ALUCTL_ADD, kSAIL_BRANCH_NONE, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_SUB, kSAIL_BRANCH_NONE, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_SRA, kSAIL_BRANCH_NONE, 1'b0, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, shift_lat(31));
        issue(kSAIL_ALUCTL_SLL, kSAIL_BRANCH_NONE, 1'b0, 32'h0000_0001, 32'd4, 32'h0000_0010, 1'b0, 1'b0, shift_lat(4));
        issue(kSAIL_ALUCTL_SRL, kSAIL_BRANCH_NONE, 1'b0, 32'h8000_00F0, 32'd1, 32'h4000_0078, 1'b0, 1'b0, shift_lat(1));
        issue(kSAIL_ALUCTL_SRL, kSAIL_BRANCH_NONE, 1'b0, 32'h0000_00F0, 32'h0000_0020, 32'h0000_00F0, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_SLT, kSAIL_BRANCH_NONE, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_SLT, kSAIL_BRANCH_NONE, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_AND, kSAIL_BRANCH_NONE, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_OR,  kSAIL_BRANCH_NONE, 1'b0, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_XOR, kSAIL_BRANCH_NONE, 1'b0, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_ADD, kSAIL_BRANCH_BLT,  1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0, 0);
        issue(kSAIL_ALUCTL_ADD, kSAIL_BRANCH_BGEU, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b1, 1'b0, 0);
        issue(kSAIL_ALUCTL_ADD, kSAIL_BRANCH_BNE,  1'b0, 32'd7, 32'd7, 32'd0, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_ADD, kSAIL_BRANCH_BEQ,  1'b0, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 0);
        issue(kSAIL_ALUCTL_ADD, kSAIL_BRANCH_BGE,  1'b0, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        issue(kSAIL_ALUCTL_ADD, kSAIL_BRANCH_BLTU, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 0);
        issue(kSAIL_ALUCTL_ADD, 3'd7,              1'b0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 0);
        issue(4'd15,            kSAIL_BRANCH_NONE, 1'b0, 32'd1, 32'd2, 32'd0, 1'b0, 1'b1, 0);
        drain();

        // Illegal op with the consumer stalling for 4 cycles.
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        issue(kSAIL_ALUCTL_ILLEGAL, kSAIL_BRANCH_NONE, 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b1, 0);
        repeat (4) @(posedge clk);
        #1;
        check("stall_still_valid", {31'd0, rsp_valid_o}, 32'd1);
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("after_handshake_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("after_handshake_ready", {31'd0, req_ready_o}, 32'd1);
        issue(kSAIL_ALUCTL_ADD, kSAIL_BRANCH_NONE, 1'b0, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
